mux4_rr_arbiter: RTL

Round-robin arbiter that shares one 4:1 data multiplexer among four requesters. It samples request lines and issues a one-hot grant. It drives the mux select pair {s1,s0} and presents the selected requester's data on a single output with a valid flag. It sits directly in front of the team's 4x1 mux datapath and is the only block allowed to drive its select lines.

---
 rtl/mux4_arb_pkg.sv | 38 +++
 rtl/mux4_rr_arbiter_if.sv | 31 +++
 rtl/mux4_dp.sv | 29 ++
 rtl/mux4_rr_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared types and helpers for the 4-way
// round-robin arbiter in front of the 4:1 mux datapath.
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // First set bit of mask, scanning last+1 .. last+4 (mod 4).
  // The final probe wraps back onto last itself.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [N_REQ-1:0] mask,
    input logic [SEL_W-1:0] last
  );
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + SEL_W'(k);
      if (!found && mask[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [N_REQ-1:0] onehot4(
    input logic [SEL_W-1:0] idx
  );
    onehot4 = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/data/grant bundle between four
// requesters (master) and the arbiter + mux (slave).
//   req  : per-requester request      d0..d3 : requester data
//   gnt  : one-hot grant              sel    : mux select {s1,s0}
//   o    : selected data (0 if idle)  vld    : grant active
interface mux4_rr_arbiter_if #(
  parameter int DW = 1
);
  import mux4_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [DW-1:0]    d0;
  logic [DW-1:0]    d1;
  logic [DW-1:0]    d2;
  logic [DW-1:0]    d3;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic [DW-1:0]    o;
  logic             vld;

  modport master (
    output req, d0, d1, d2, d3,
    input  gnt, sel, o, vld
  );

  modport slave (
    input  req, d0, d1, d2, d3,
    output gnt, sel, o, vld
  );

endinterface

// File: rtl/mux4_dp.sv
// mux4_dp: AND-OR 4:1 data mux with output enable.
// Ports: sel (2b), d0..d3 (DW), en, o = en ? d[sel] : 0.
module mux4_dp #(
  parameter int DW = 1
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic          en,
  output logic [DW-1:0] o
);

  logic [3:0] dec;

  // en is folded into the decode so a disabled mux
  // forces every AND leg to zero.
  assign dec[0] = en & ~sel[1] & ~sel[0];
  assign dec[1] = en & ~sel[1] &  sel[0];
  assign dec[2] = en &  sel[1] & ~sel[0];
  assign dec[3] = en &  sel[1] &  sel[0];

  assign o = ({DW{dec[0]}} & d0)
           | ({DW{dec[1]}} & d1)
           | ({DW{dec[2]}} & d2)
           | ({DW{dec[3]}} & d3);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of the 4:1 mux select lines.
// Ports: clk, rst_n (async, active-low), bus (slave modport):
//   req in, d0..d3 in, gnt/sel registered out, vld, o = d[sel]&vld.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  mux4_rr_arbiter_if.slave bus
);

  localparam logic [3:0] HOLD = 4'(MAX_HOLD);

  state_t           state;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] last;
  logic [3:0]       cnt;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] others;
  logic [SEL_W-1:0] pick_all;
  logic [SEL_W-1:0] pick_oth;
  logic             own_req;
  logic             at_max;
  logic             vld;

  assign req      = bus.req;
  assign others   = req & ~gnt;
  assign pick_all = rr_pick(req, last);
  assign pick_oth = rr_pick(others, last);
  assign own_req  = req[sel];
  assign at_max   = (cnt == HOLD);
  assign vld      = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      last  <= 2'd3;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= onehot4(pick_all);
            sel   <= pick_all;
            last  <= pick_all;
            cnt   <= 4'd1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!own_req) begin
            // Owner bit is 0 here, so pick_all
            // already excludes the old owner.
            if (|req) begin
              gnt  <= onehot4(pick_all);
              sel  <= pick_all;
              last <= pick_all;
              cnt  <= 4'd1;
            end else begin
              gnt   <= '0;
              cnt   <= '0;
              state <= IDLE;
            end
          end else if (at_max && |others) begin
            gnt  <= onehot4(pick_oth);
            sel  <= pick_oth;
            last <= pick_oth;
            cnt  <= 4'd1;
          end else if (!at_max) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt = gnt;
  assign bus.sel = sel;
  assign bus.vld = vld;

  mux4_dp #(
    .DW(DW)
  ) u_dp (
    .sel (sel),
    .d0  (bus.d0),
    .d1  (bus.d1),
    .d2  (bus.d2),
    .d3  (bus.d3),
    .en  (vld),
    .o   (bus.o)
  );

endmodule
